// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: turns a checksummed, length-prefixed byte stream
// into big-endian 32-bit instruction-memory writes and holds the CPU in reset until the image verifies.
module imem_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_rst,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [2:0] {
    S_HDR0,
    S_HDR1,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_WIDTH;

  state_t                r_state;
  state_t                w_state_next;
  logic [15:0]           r_cnt;
  logic [7:0]            r_xor;
  logic [1:0]            r_byte_cnt;
  logic [23:0]           r_shift;
  logic [16:0]           r_word_cnt;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic                  r_we;
  logic                  r_done;
  logic                  r_err;
  logic                  r_cpu_rst;

  logic                  w_active;
  logic                  w_accept;
  logic [15:0]           w_count;
  logic                  w_last_word;

  assign w_active    = (r_state == S_HDR0) || (r_state == S_HDR1) ||
                       (r_state == S_DATA) || (r_state == S_CSUM);
  assign in_ready    = w_active && !rst;
  assign w_accept    = in_valid && in_ready;
  // Full count as it will be once the low header byte lands this cycle.
  assign w_count     = {r_cnt[15:8], in_data};
  assign w_last_word = ((r_word_cnt + 17'd1) == {1'b0, r_cnt});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_HDR0;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_accept) begin
      case (r_state)
        S_HDR0: w_state_next = S_HDR1;
        S_HDR1: begin
          if ({1'b0, w_count} > MAX_WORDS) begin
            w_state_next = S_ERROR;
          end else if (w_count == 16'd0) begin
            w_state_next = S_CSUM;
          end else begin
            w_state_next = S_DATA;
          end
        end
        S_DATA: begin
          if (r_byte_cnt == 2'd3 && w_last_word) begin
            w_state_next = S_CSUM;
          end
        end
        S_CSUM: w_state_next = (in_data == r_xor) ? S_DONE : S_ERROR;
        default: w_state_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_xor      <= '0;
      r_byte_cnt <= '0;
      r_shift    <= '0;
      r_word_cnt <= '0;
      r_wr_ptr   <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_we       <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_cpu_rst  <= 1'b1;
    end else begin
      r_we <= 1'b0;
      if (w_accept) begin
        if (r_state != S_CSUM) begin
          r_xor <= r_xor ^ in_data;
        end
        case (r_state)
          S_HDR0: r_cnt[15:8] <= in_data;
          S_HDR1: r_cnt[7:0]  <= in_data;
          S_DATA: begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            r_shift    <= {r_shift[15:0], in_data};
            if (r_byte_cnt == 2'd3) begin
              r_we       <= 1'b1;
              r_wdata    <= {r_shift, in_data};
              r_addr     <= r_wr_ptr;
              r_wr_ptr   <= r_wr_ptr + 1'b1;
              r_word_cnt <= r_word_cnt + 17'd1;
            end
          end
          default: ;
        endcase
        if (w_state_next == S_DONE) begin
          r_done    <= 1'b1;
          r_cpu_rst <= 1'b0;
        end
        if (w_state_next == S_ERROR) begin
          r_err <= 1'b1;
        end
      end
    end
  end

  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign cpu_rst    = r_cpu_rst;
  assign done       = r_done;
  assign err        = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and random frames against a frame-level
// model that derives expected writes, acceptance length and outcome from the frame bytes.
module tb_imem_loader;

  localparam int AW       = 8;
  localparam int CAP      = 1 << AW;
  localparam int WAIT_MAX = 8;

  typedef logic [7:0] byte_q_t[$];

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_rst;
  logic          done;
  logic          err;

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_rst(cpu_rst), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int frame_no = 0;

  logic [AW-1:0] got_addr[$];
  logic [31:0]   got_data[$];
  logic [AW-1:0] exp_addr[$];
  logic [31:0]   exp_data[$];
  int            exp_acc;
  logic          exp_done;
  logic          exp_err;
  logic          prev_we = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Write monitor; a strobe seen on two consecutive cycles is a protocol error.
  always @(negedge clk) begin
    if (imem_we) begin
      got_addr.push_back(imem_addr);
      got_data.push_back(imem_wdata);
      check_eq("we_one_cycle", {63'd0, prev_we}, 64'd0);
    end
    prev_we = imem_we;
  end

  // Frame-level reference: outcome depends only on header, payload and checksum byte.
  task automatic model(input byte_q_t b);
    int n;
    logic [7:0] x;
    exp_addr.delete();
    exp_data.delete();
    n = int'({b[0], b[1]});
    if (n > CAP) begin
      exp_acc  = 2;
      exp_done = 1'b0;
      exp_err  = 1'b1;
      return;
    end
    x = 8'h00;
    for (int i = 0; i < 2 + 4 * n; i++) x = x ^ b[i];
    for (int w = 0; w < n; w++) begin
      exp_addr.push_back(AW'(w % CAP));
      exp_data.push_back({b[2+4*w], b[3+4*w], b[4+4*w], b[5+4*w]});
    end
    exp_acc  = 3 + 4 * n;
    exp_done = (b[2+4*n] == x);
    exp_err  = !exp_done;
  endtask

  task automatic build(input int n, input bit good, input int extra, output byte_q_t q);
    logic [7:0] x;
    logic [7:0] v;
    q.delete();
    q.push_back(8'(n >> 8));
    q.push_back(8'(n));
    if (n > CAP) begin
      for (int i = 0; i < 4; i++) q.push_back(8'($urandom));
      return;
    end
    x = q[0] ^ q[1];
    for (int i = 0; i < 4 * n; i++) begin
      v = 8'($urandom);
      q.push_back(v);
      x = x ^ v;
    end
    q.push_back(good ? x : (x ^ 8'($urandom_range(1, 255))));
    for (int i = 0; i < extra; i++) q.push_back(8'($urandom));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check_eq("rst_we", {63'd0, imem_we}, 64'd0);
    check_eq("rst_addr", {56'd0, imem_addr}, 64'd0);
    check_eq("rst_wdata", {32'd0, imem_wdata}, 64'd0);
    check_eq("rst_cpu_rst", {63'd0, cpu_rst}, 64'd1);
    check_eq("rst_done", {63'd0, done}, 64'd0);
    check_eq("rst_err", {63'd0, err}, 64'd0);
    got_addr.delete();
    got_data.delete();
    rst = 1'b0;
    #1;
    check_eq("in_ready_after_rst", {63'd0, in_ready}, 64'd1);
  endtask

  // mode 0: full rate, 1: in_valid alternates 1,0,1,0, 2: random idle gaps.
  task automatic send(input byte_q_t b, input int limit, input int mode, output int accepted);
    int waits;
    int gap;
    accepted = 0;
    @(negedge clk);
    for (int i = 0; i < limit; i++) begin
      gap = (mode == 1 && i > 0) ? 1 : (mode == 2 ? int'($urandom_range(0, 2)) : 0);
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
      in_valid = 1'b1;
      in_data  = b[i];
      waits = 0;
      while (!in_ready && waits < WAIT_MAX) begin
        @(negedge clk);
        waits++;
      end
      if (!in_ready) break;
      @(posedge clk);
      accepted++;
      @(negedge clk);
      if (accepted == exp_acc) begin
        check_eq("final_done", {63'd0, done}, {63'd0, exp_done});
        check_eq("final_err", {63'd0, err}, {63'd0, exp_err});
        check_eq("final_cpu_rst", {63'd0, cpu_rst}, {63'd0, !exp_done});
        check_eq("final_no_we", {63'd0, imem_we}, 64'd0);
        check_eq("final_ready_low", {63'd0, in_ready}, 64'd0);
      end else begin
        check_eq("early_done", {62'd0, done, err}, 64'd0);
        check_eq("early_cpu_rst", {63'd0, cpu_rst}, 64'd1);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic run(input byte_q_t b, input int mode);
    int acc;
    do_reset();
    model(b);
    send(b, b.size(), mode, acc);
    repeat (2) @(negedge clk);
    check_eq("accepted", 64'(acc), 64'(exp_acc));
    check_eq("write_count", 64'(got_addr.size()), 64'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      check_eq("write_addr", {56'd0, got_addr[i]}, {56'd0, exp_addr[i]});
      check_eq("write_data", {32'd0, got_data[i]}, {32'd0, exp_data[i]});
    end
    check_eq("end_ready", {63'd0, in_ready}, 64'd0);
    check_eq("end_done", {63'd0, done}, {63'd0, exp_done});
    check_eq("end_err", {63'd0, err}, {63'd0, exp_err});
    check_eq("end_cpu_rst", {63'd0, cpu_rst}, {63'd0, !exp_done});
    if (exp_addr.size() > 0) begin
      check_eq("hold_addr", {56'd0, imem_addr}, {56'd0, exp_addr[$]});
      check_eq("hold_wdata", {32'd0, imem_wdata}, {32'd0, exp_data[$]});
    end
    $display("frame %0d mode=%0d bytes=%0d accepted=%0d writes=%0d done=%0b err=%0b",
             frame_no, mode, b.size(), acc, got_addr.size(), done, err);
    frame_no++;
  endtask

  initial begin
    byte_q_t fa;
    byte_q_t fb;
    byte_q_t q;
    int acc;
    int n;

    fa = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h2F};
    run(fa, 0);
    fb = fa;
    fb[10] = 8'h2E;
    fb.push_back(8'h11);
    run(fb, 0);
    q = '{8'h00, 8'h00, 8'h00};
    run(q, 0);
    q = '{8'h01, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run(q, 0);
    run(fa, 1);

    // Abort after six bytes, then replay the whole frame.
    do_reset();
    model(fa);
    send(fa, 6, 0, acc);
    check_eq("partial_accepted", 64'(acc), 64'd6);
    run(fa, 0);

    build(CAP, 1'b1, 1, q);
    run(q, 2);

    for (int k = 0; k < 10; k++) begin
      if ($urandom_range(0, 9) == 0) n = int'($urandom_range(CAP + 1, 65535));
      else n = int'($urandom_range(0, 6));
      build(n, $urandom_range(0, 3) != 0, int'($urandom_range(0, 2)), q);
      run(q, int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
